tt_sweep_harness: RTL and testbench

// - Sequential stimulus/response stage around a 7-input single-output Boolean network (majority-gate

---
 rtl/tt_sweep_pkg.sv | 19 +
 rtl/tt_sweep_harness_if.sv | 29 ++
 rtl/tt_capture_delay.sv | 37 +++
 rtl/tt_sweep_harness.sv | 112 +++++++++++
 tb/tb_tt_sweep_harness.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep harness.
// Holds the FSM state encoding, the table-width helper and the default signature.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int tt_w(input int n);
      return 1 << n;
   endfunction

   localparam int           DEF_N_IN   = 7;
   localparam logic [127:0] DEF_EXP_TT = 128'hfee8eac0fce8e8c0fce8e8c0fca8e880;

endpackage

// File: rtl/tt_sweep_harness_if.sv
// Bundle between the sweep harness and its environment: start request, network
// vector/response pair, and the sweep result (busy, done, tt, match).
interface tt_sweep_harness_if
   import tt_sweep_pkg::*;
#(
   parameter int N_IN = DEF_N_IN
);

   localparam int TT_W = tt_w(N_IN);

   logic            start;
   logic [N_IN-1:0] x_out;
   logic            f_in;
   logic            busy;
   logic            done;
   logic [TT_W-1:0] tt;
   logic            match;

   modport master (
      output start, f_in,
      input  x_out, busy, done, tt, match
   );

   modport slave (
      input  start, f_in,
      output x_out, busy, done, tt, match
   );

endinterface

// File: rtl/tt_capture_delay.sv
// Delay line carrying {valid, idx} alongside the network latency so each response
// lands in the table bit of the vector that produced it. PIPE_LAT=0 is pure wiring.
module tt_capture_delay #(
   parameter int N_IN     = 7,
   parameter int PIPE_LAT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_vld,
   input  logic [N_IN-1:0] push_idx,
   output logic            cap_vld,
   output logic [N_IN-1:0] cap_idx
);

   if (PIPE_LAT == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign cap_vld    = push_vld;
      assign cap_idx    = push_idx;
   end else begin : g_pipe
      logic [N_IN:0] line_p [PIPE_LAT];

      // Cleared on reset so an abandoned sweep never writes into the next one.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) line_p[i] <= '0;
         end else begin
            line_p[0] <= {push_vld, push_idx};
            for (int i = 1; i < PIPE_LAT; i++) line_p[i] <= line_p[i-1];
         end
      end

      assign cap_vld = line_p[PIPE_LAT-1][N_IN];
      assign cap_idx = line_p[PIPE_LAT-1][N_IN-1:0];
   end

endmodule

// File: rtl/tt_sweep_harness.sv
// Drives every input vector onto a Boolean network, captures its response into a
// truth table and compares the table against a fixed signature.
module tt_sweep_harness
   import tt_sweep_pkg::*;
#(
   parameter int                     N_IN     = DEF_N_IN,
   parameter int                     PIPE_LAT = 0,
   parameter logic [tt_w(N_IN)-1:0]  EXP_TT   = DEF_EXP_TT
) (
   input logic                 clk,
   input logic                 rst_n,
   tt_sweep_harness_if.slave   bus
);

   localparam int TT_W  = tt_w(N_IN);
   localparam int CNT_W = N_IN + 1;
   localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TT_W - 1);
   localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(PIPE_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DRN_W-1:0]  drn_cnt;
   logic [TT_W-1:0]   tt_q;
   logic [TT_W-1:0]   tt_nxt;
   logic              match_q;
   logic              cap_vld;
   logic [N_IN-1:0]   cap_idx;
   logic              sweep_last;
   logic              drain_last;
   logic              accept;

   assign sweep_last = (state == SWEEP) && (cnt == LAST_IDX);
   assign drain_last = (state == DRAIN) && (drn_cnt == LAST_DRN);
   assign accept     = (state == IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)  state_nxt = SWEEP;
         SWEEP:   if (sweep_last) state_nxt = (PIPE_LAT > 0) ? DRAIN : DONE;
         DRAIN:   if (drain_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state == SWEEP) || (state == DRAIN);
      bus.done  = (state == DONE);
      bus.x_out = cnt[N_IN-1:0];
      bus.tt    = tt_q;
      bus.match = match_q;
   end

   // Vector counter holds the last index through DRAIN/DONE and is back at 0 for IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         drn_cnt <= '0;
      end else begin
         case (state)
            SWEEP:   if (!sweep_last) cnt <= cnt + 1'b1;
            DRAIN:   drn_cnt <= drn_cnt + 1'b1;
            DONE: begin
               cnt     <= '0;
               drn_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   tt_capture_delay #(
      .N_IN     (N_IN),
      .PIPE_LAT (PIPE_LAT)
   ) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (state == SWEEP),
      .push_idx (cnt[N_IN-1:0]),
      .cap_vld  (cap_vld),
      .cap_idx  (cap_idx)
   );

   always_comb begin
      tt_nxt = tt_q;
      if (cap_vld) tt_nxt[cap_idx] = bus.f_in;
   end

   // The final capture and the signature compare share the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q    <= '0;
         match_q <= 1'b0;
      end else if (accept) begin
         tt_q    <= '0;
         match_q <= 1'b0;
      end else begin
         tt_q <= tt_nxt;
         if ((state_nxt == DONE) && (state != DONE)) match_q <= (tt_nxt == EXP_TT);
      end
   end

endmodule

// File: tb/tb_tt_sweep_harness.sv
// Directed bench for the sweep harness: a combinational and a twice-registered
// network model, reset, ignored restarts and back-to-back sweeps.
`timescale 1ns/1ps
module tb_tt_sweep_harness;
   import tt_sweep_pkg::*;

   localparam logic [127:0] NET_TT = 128'hfee8eac0fce8e8c0fce8e8c0fca8e880;
   localparam logic [127:0] ALT_TT = {32{4'ha}};

   logic clk = 1'b0;
   logic rst_n;
   int   mode;

   always #5 clk = ~clk;

   tt_sweep_harness_if #(.N_IN(7)) bus0 ();
   tt_sweep_harness_if #(.N_IN(7)) bus2 ();

   tt_sweep_harness #(.N_IN(7), .PIPE_LAT(0), .EXP_TT(NET_TT)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   tt_sweep_harness #(.N_IN(7), .PIPE_LAT(2), .EXP_TT(NET_TT)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   // Network models: mode 0 reference function, 1 passes x0, 2 constant zero.
   assign bus0.f_in = (mode == 0) ? NET_TT[bus0.x_out] :
                      (mode == 1) ? bus0.x_out[0] : 1'b0;

   logic net2_p0, net2_p1;
   always @(posedge clk) begin
      net2_p0 <= NET_TT[bus2.x_out];
      net2_p1 <= net2_p0;
   end
   assign bus2.f_in = net2_p1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_cnt0 = 0, match_cnt0 = 0, last_done0 = 0, prev_done0 = 0;
   always @(negedge clk) begin
      if (bus0.done) begin
         done_cnt0  <= done_cnt0 + 1;
         match_cnt0 <= match_cnt0 + (bus0.match ? 1 : 0);
         prev_done0 <= last_done0;
         last_done0 <= cyc;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start on one instance and waits (bounded) for done. lat counts the start
   // cycle and the done cycle inclusively; -1 means done never came.
   task automatic sweep(input bit sel, input bit repulse, output int lat, output int busy_n);
      int s;
      bit seen;
      @(negedge clk);
      if (sel) bus2.start = 1'b1;
      else     bus0.start = 1'b1;
      s      = cyc;
      lat    = -1;
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 1; i < 400 && !seen; i++) begin
         @(negedge clk);
         bus0.start = repulse && (i == 11 || i == 128);
         bus2.start = 1'b0;
         if (sel ? bus2.busy : bus0.busy) busy_n++;
         if (sel ? bus2.done : bus0.done) begin
            seen = 1'b1;
            lat  = cyc - s + 1;
         end
      end
   endtask

   int lat, busy_n, d0, m0;

   initial begin
      rst_n      = 1'b0;
      mode       = 0;
      bus0.start = 1'b0;
      bus2.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_x_out", bus0.x_out, 0);
      chk("rst_busy",  bus0.busy,  0);
      chk("rst_done",  bus0.done,  0);
      chk("rst_tt",    bus0.tt,    0);
      chk("rst_match", bus0.match, 0);
      chk("rst_busy2", bus2.busy,  0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sweep(1'b0, 1'b0, lat, busy_n);
      chk("net_lat",   lat,        130);
      chk("net_busy",  busy_n,     128);
      chk("net_tt",    bus0.tt,    NET_TT);
      chk("net_match", bus0.match, 1);
      @(negedge clk);
      chk("idle_done",  bus0.done,  0);
      chk("idle_x_out", bus0.x_out, 0);
      chk("idle_tt",    bus0.tt,    NET_TT);
      chk("idle_match", bus0.match, 1);

      mode = 1;
      sweep(1'b0, 1'b0, lat, busy_n);
      chk("x0_tt",    bus0.tt,    ALT_TT);
      chk("x0_match", bus0.match, 0);

      mode = 2;
      sweep(1'b0, 1'b0, lat, busy_n);
      chk("zero_tt",    bus0.tt,    0);
      chk("zero_match", bus0.match, 0);

      sweep(1'b1, 1'b0, lat, busy_n);
      chk("lat2_lat",   lat,        132);
      chk("lat2_busy",  busy_n,     130);
      chk("lat2_tt",    bus2.tt,    NET_TT);
      chk("lat2_match", bus2.match, 1);

      mode = 0;
      repeat (2) @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_x_out", bus0.x_out, 50);
      d0    = done_cnt0;
      rst_n = 1'b0;
      #1;
      chk("async_x_out", bus0.x_out, 0);
      chk("async_busy",  bus0.busy,  0);
      chk("async_tt",    bus0.tt,    0);
      chk("async_match", bus0.match, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("abandon_no_done", done_cnt0 - d0, 0);
      sweep(1'b0, 1'b0, lat, busy_n);
      chk("after_rst_lat",   lat,        130);
      chk("after_rst_tt",    bus0.tt,    NET_TT);
      chk("after_rst_match", bus0.match, 1);

      repeat (3) @(negedge clk);
      d0 = done_cnt0;
      sweep(1'b0, 1'b1, lat, busy_n);
      chk("repulse_lat", lat,     130);
      chk("repulse_tt",  bus0.tt, NET_TT);
      repeat (5) @(negedge clk);
      chk("repulse_one_done", done_cnt0 - d0, 1);
      chk("repulse_idle",     bus0.busy,      0);

      d0 = done_cnt0;
      m0 = match_cnt0;
      @(negedge clk);
      bus0.start = 1'b1;
      repeat (300) @(negedge clk);
      bus0.start = 1'b0;
      repeat (200) @(negedge clk);
      chk("held_dones",   done_cnt0 - d0,              3);
      chk("held_matches", match_cnt0 - m0,             3);
      chk("held_gap",     last_done0 - prev_done0 + 1, 131);
      chk("held_tt",      bus0.tt,                     NET_TT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
